credit_tx_w8: RTL and testbench

Credit-based transmitter that sits directly upstream of the 8-entry receive FIFO and drives its write port. It accepts words on a valid/ready slave interface, buffers them in a 2-entry skid buffer, and issues a FIFO write only while it holds a credit. Credits are returned one per word the downstream consumer pops, so the FIFO can never be written while full.

---
 rtl/credit_pkg.sv | 10 +
 rtl/credit_skid2.sv | 73 +++++++
 rtl/credit_tx_w8.sv | 59 +++++
 tb/tb_credit_tx_w8.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/credit_pkg.sv
// Shared types and defaults for the credit-based FIFO transmitter.
package credit_pkg;
    typedef enum logic [1:0] {
        SK_EMPTY = 2'd0,
        SK_ONE   = 2'd1,
        SK_TWO   = 2'd2
    } skid_state_t;

    localparam int CREDITS_DEFAULT = 8;
endpackage

// File: rtl/credit_skid2.sv
// Two-entry skid buffer; buf0 is always the head word.
// state    | meaning
// SK_EMPTY | no words held
// SK_ONE   | head word in buf0
// SK_TWO   | head in buf0, next word in buf1, not ready
module credit_skid2
    import credit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] head,
    output logic             head_valid,
    input  logic             pop
);
    skid_state_t      state, state_nxt;
    logic [WIDTH-1:0] buf0, buf1;
    logic             rdy_en;
    logic             accept;

    assign accept = in_valid & in_ready;
    assign head   = buf0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= SK_EMPTY;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SK_EMPTY: if (accept) state_nxt = SK_ONE;
            SK_ONE: begin
                if (accept && !pop)      state_nxt = SK_TWO;
                else if (pop && !accept) state_nxt = SK_EMPTY;
            end
            SK_TWO:   if (pop) state_nxt = SK_ONE;
            default:  state_nxt = SK_EMPTY;
        endcase
    end

    // ready is held low until the first edge after reset release
    always_comb begin
        in_ready   = rdy_en && (state != SK_TWO);
        head_valid = (state != SK_EMPTY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            case (state)
                SK_EMPTY: if (accept) buf0 <= in_data;
                SK_ONE: begin
                    if (accept && pop) buf0 <= in_data;
                    else if (accept)   buf1 <= in_data;
                end
                SK_TWO:   if (pop) buf0 <= buf1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/credit_tx_w8.sv
// Credit-gated transmitter feeding the downstream FIFO write port.
module credit_tx_w8
    import credit_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int CREDITS = CREDITS_DEFAULT,
    localparam int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_we,
    input  logic             credit_ret,
    output logic [CNT_W-1:0] credit_cnt,
    output logic             credit_zero,
    output logic             overflow_err
);
    logic [WIDTH-1:0] head;
    logic             head_valid;
    logic             send;

    assign send        = head_valid && (credit_cnt != '0);
    assign credit_zero = (credit_cnt == '0);

    credit_skid2 #(.WIDTH(WIDTH)) u_skid (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (s_data),
        .in_valid   (s_valid),
        .in_ready   (s_ready),
        .head       (head),
        .head_valid (head_valid),
        .pop        (send)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_we        <= 1'b0;
            tx_data      <= '0;
            credit_cnt   <= CNT_W'(CREDITS);
            overflow_err <= 1'b0;
        end else begin
            tx_we <= send;
            if (send) tx_data <= head;
            // a return while already full saturates and flags the protocol error
            case ({send, credit_ret})
                2'b10: credit_cnt <= credit_cnt - CNT_W'(1);
                2'b01: begin
                    if (credit_cnt == CNT_W'(CREDITS)) overflow_err <= 1'b1;
                    else                               credit_cnt   <= credit_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_credit_tx_w8.sv
// Randomized and directed bench for credit_tx_w8 against a queue-based model.
module tb_credit_tx_w8;
    localparam int CREDITS = 8;

    logic       clk;
    logic       reset_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] tx_data;
    logic       tx_we;
    logic       credit_ret;
    logic [3:0] credit_cnt;
    logic       credit_zero;
    logic       overflow_err;

    credit_tx_w8 dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .tx_data      (tx_data),
        .tx_we        (tx_we),
        .credit_ret   (credit_ret),
        .credit_cnt   (credit_cnt),
        .credit_zero  (credit_zero),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [7:0] q[$];
    int         m_cred;
    bit         m_ovf, m_we, m_started, m_acc;
    logic [7:0] m_tx;
    int         n_sends;
    int         cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cred    = CREDITS;
        m_ovf     = 1'b0;
        m_we      = 1'b0;
        m_tx      = 8'h00;
        m_started = 1'b0;
        m_acc     = 1'b0;
    endtask

    function automatic bit m_ready();
        return m_started && (q.size() < 2);
    endfunction

    task automatic model_edge();
        bit snd;
        if (!reset_n) begin
            model_reset();
        end else begin
            m_acc = s_valid && m_ready();
            snd   = (q.size() > 0) && (m_cred > 0);
            m_we  = snd;
            if (snd) begin
                m_tx = q.pop_front();
                n_sends++;
            end
            if (m_acc) q.push_back(s_data);
            if (snd && !credit_ret) m_cred--;
            else if (credit_ret && !snd) begin
                if (m_cred == CREDITS) m_ovf = 1'b1;
                else                   m_cred++;
            end
            m_started = 1'b1;
        end
    endtask

    task automatic check_all();
        check("tx_we",        32'(tx_we),        32'(m_we));
        check("tx_data",      32'(tx_data),      32'(m_tx));
        check("credit_cnt",   32'(credit_cnt),   32'(m_cred));
        check("credit_zero",  32'(credit_zero),  32'(m_cred == 0));
        check("s_ready",      32'(s_ready),      32'(m_ready()));
        check("overflow_err", 32'(overflow_err), 32'(m_ovf));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_all();
    endtask

    int idx, pulses, first_acc, first_we, guard, bubbles;
    logic [7:0] seen[$];

    initial begin
        reset_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; credit_ret = 1'b0;
        model_reset();
        n_sends = 0;

        // reset held for 3 cycles
        repeat (3) step();
        check("rst_cnt8", 32'(credit_cnt), 32'd8);
        check("rst_ready0", 32'(s_ready), 32'd0);
        reset_n = 1'b1;
        step();
        check("ready_after_release", 32'(s_ready), 32'd1);

        // burst of 10 words, no credit return
        idx = 0; pulses = 0; first_acc = -1; first_we = -1;
        for (int i = 0; i < 16; i++) begin
            s_valid = (idx < 10);
            s_data  = 8'(idx + 1);
            step();
            if (m_acc) begin
                if (first_acc < 0) first_acc = cyc;
                idx++;
            end
            if (tx_we) begin
                if (first_we < 0) first_we = cyc;
                pulses++;
                seen.push_back(tx_data);
            end
        end
        s_valid = 1'b0;
        check("burst_pulses", 32'(pulses), 32'd8);
        check("burst_latency", 32'(first_we - first_acc), 32'd1);
        for (int k = 0; k < seen.size() && k < 8; k++)
            check("burst_order", 32'(seen[k]), 32'(k + 1));
        check("burst_zero", 32'(credit_zero), 32'd1);
        check("burst_ready0", 32'(s_ready), 32'd0);

        // single credit release
        credit_ret = 1'b1;
        step();
        credit_ret = 1'b0;
        check("rel_cnt1", 32'(credit_cnt), 32'd1);
        check("rel_no_same_edge", 32'(tx_we), 32'd0);
        step();
        check("rel_we", 32'(tx_we), 32'd1);
        check("rel_data09", 32'(tx_data), 32'h09);
        check("rel_cnt0", 32'(credit_cnt), 32'd0);
        check("rel_ready1", 32'(s_ready), 32'd1);

        // settle at credit_cnt == 3 with empty buffer
        guard = 0;
        while (!(q.size() == 0 && m_cred == 3) && guard < 40) begin
            credit_ret = (m_cred < 3);
            step();
            guard++;
        end
        credit_ret = 1'b0;
        check("settle3", 32'(guard < 40), 32'd1);
        step();

        // steady stream with a return on every send
        bubbles = 0;
        for (int i = 0; i < 24; i++) begin
            s_valid    = 1'b1;
            s_data     = 8'($urandom);
            credit_ret = (q.size() > 0) && (m_cred > 0);
            step();
            if (i >= 1 && !tx_we) bubbles++;
            check("steady_cnt3", 32'(credit_cnt), 32'd3);
        end
        s_valid = 1'b0;
        check("steady_bubbles", 32'(bubbles), 32'd0);
        credit_ret = (q.size() > 0) && (m_cred > 0);
        step();
        credit_ret = 1'b0;
        step();

        // fill credits, then overflow
        guard = 0;
        while (m_cred < CREDITS && guard < 20) begin
            credit_ret = 1'b1;
            step();
            guard++;
        end
        check("fill8", 32'(credit_cnt), 32'd8);
        check("no_ovf_yet", 32'(overflow_err), 32'd0);
        credit_ret = 1'b1;
        step();
        credit_ret = 1'b0;
        check("ovf_set", 32'(overflow_err), 32'd1);
        check("ovf_cnt8", 32'(credit_cnt), 32'd8);
        repeat (3) step();
        check("ovf_sticky", 32'(overflow_err), 32'd1);

        // reset in the middle of a burst
        n_sends = 0; guard = 0;
        while (n_sends < 4 && guard < 20) begin
            s_valid = 1'b1;
            s_data  = 8'($urandom);
            step();
            guard++;
        end
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_we0", 32'(tx_we), 32'd0);
        check("mid_rst_cnt8", 32'(credit_cnt), 32'd8);
        check("mid_rst_ovf0", 32'(overflow_err), 32'd0);
        s_valid = 1'b0;
        step();
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (tx_we) pulses++;
        end
        check("mid_rst_no_resend", 32'(pulses), 32'd0);

        // randomized traffic with legal credit returns
        for (int i = 0; i < 400; i++) begin
            s_valid    = ($urandom_range(0, 3) != 0);
            s_data     = 8'($urandom);
            credit_ret = (m_cred < CREDITS) && ($urandom_range(0, 2) != 0);
            step();
        end
        s_valid = 1'b0; credit_ret = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
